tlb_miss_ctrl: RTL

Parametrised multi-channel TLB miss controller; successor to the single-bit sticky miss latch used by the instruction and data TLBs. Each of `NCH` channels holds a sticky miss flag plus the faulting virtual page number. A round-robin arbiter presents one pending miss at a time to a shared refill port with a req/ack handshake. It sits between the per-pipe TLB lookup logic and the page-table walker.

---
 rtl/tlb_miss_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/tlb_miss_ctrl.sv
// Multi-channel sticky TLB miss capture with a round-robin req/ack refill port to the page-table walker.
// Optional refill watchdog enabled by defining TLB_MISS_TIMEOUT_EN (sets sticky timeout_err_o, drops the request).
module tlb_miss_ctrl #(
  parameter int NCH     = 2,
  parameter int VPN_W   = 20,
  parameter int TIMEOUT = 255,
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NCH-1:0]         miss_in_i,
  input  logic [NCH*VPN_W-1:0]   miss_vpn_i,
  input  logic                   flush_i,
  output logic [NCH-1:0]         miss_o,
  output logic                   refill_req_o,
  output logic [CH_W-1:0]        refill_ch_o,
  output logic [VPN_W-1:0]       refill_vpn_o,
  input  logic                   refill_ack_i,
  output logic                   timeout_err_o
);

  if (NCH < 1 || NCH > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_chk
    $error("tlb_miss_ctrl: parameter out of range");
  end

  typedef enum logic {IDLE, REQ} state_e;

  state_e             state_q;
  logic [NCH-1:0]     pend_q, pend_d, pend_clr, cap;
  logic [VPN_W-1:0]   vpn_q [NCH];
  logic [CH_W-1:0]    grant_q, last_q, pick;
  logic               pick_vld;
  logic               req_q;
  logic [VPN_W-1:0]   rvpn_q;
  logic               done;
  logic [CH_W:0]      idx;

`ifdef TLB_MISS_TIMEOUT_EN
  logic [7:0]         cnt_q;
  logic               terr_q;
  logic               to_hit;
`endif

  // Round-robin: the lowest distance above last_q wins, so scan from far to near.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int k = NCH; k >= 1; k--) begin
      idx = {1'b0, last_q} + (CH_W+1)'(k);
      if (idx >= (CH_W+1)'(NCH)) idx = idx - (CH_W+1)'(NCH);
      if (pend_q[idx[CH_W-1:0]]) begin
        pick     = idx[CH_W-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    done = 1'b0;
`ifdef TLB_MISS_TIMEOUT_EN
    to_hit = 1'b0;
`endif
    if (state_q == REQ) begin
      if (refill_ack_i) begin
        done = 1'b1;
      end
`ifdef TLB_MISS_TIMEOUT_EN
      else if (cnt_q == 8'(TIMEOUT - 1)) begin
        done   = 1'b1;
        to_hit = 1'b1;
      end
`endif
    end
    pend_clr = pend_q;
    if (done) pend_clr[grant_q] = 1'b0;
    // A miss arriving on the completing channel re-arms it instead of being dropped.
    cap    = miss_in_i & ~pend_clr & {NCH{~flush_i}};
    pend_d = flush_i ? '0 : (pend_clr | cap);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pend_q  <= '0;
      grant_q <= '0;
      last_q  <= CH_W'(NCH - 1);
      req_q   <= 1'b0;
      rvpn_q  <= '0;
      for (int i = 0; i < NCH; i++) vpn_q[i] <= '0;
`ifdef TLB_MISS_TIMEOUT_EN
      cnt_q   <= '0;
      terr_q  <= 1'b0;
`endif
    end else begin
      pend_q <= pend_d;
      for (int i = 0; i < NCH; i++) begin
        if (cap[i]) vpn_q[i] <= miss_vpn_i[i*VPN_W +: VPN_W];
      end
      if (flush_i) begin
        state_q <= IDLE;
        req_q   <= 1'b0;
        grant_q <= '0;
        rvpn_q  <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (pick_vld) begin
              state_q <= REQ;
              req_q   <= 1'b1;
              grant_q <= pick;
              rvpn_q  <= vpn_q[pick];
`ifdef TLB_MISS_TIMEOUT_EN
              cnt_q   <= '0;
`endif
            end
          end
          REQ: begin
            if (done) begin
              state_q <= IDLE;
              req_q   <= 1'b0;
              last_q  <= grant_q;
              grant_q <= '0;
              rvpn_q  <= '0;
`ifdef TLB_MISS_TIMEOUT_EN
              if (to_hit) terr_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 8'd1;
`endif
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign miss_o       = pend_q;
  assign refill_req_o = req_q;
  assign refill_ch_o  = grant_q;
  assign refill_vpn_o = rvpn_q;
`ifdef TLB_MISS_TIMEOUT_EN
  assign timeout_err_o = terr_q;
`else
  assign timeout_err_o = 1'b0;
`endif

endmodule
